// File: rtl/qeciphy_crc_check_mc.sv
// Multi-channel CRC validation checker: captures the expected CRC word on a boundary,
// compares it chunk-wise against NUM_CH calculated CRCs, and tracks link health.
module qeciphy_crc_check_mc #(
    parameter int NUM_CH      = 4,
    parameter int CRC_W       = 16,
    parameter int CMP_W       = 8,
    parameter int FAIL_THRESH = 3,
    parameter int GOOD_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    crc_boundary_i,
    input  logic [NUM_CH*CRC_W-1:0] expected_i,
    input  logic [NUM_CH*CRC_W-1:0] crc_i,
    input  logic                    crc_valid_i,
    input  logic [NUM_CH-1:0]       ch_mask_i,
    input  logic                    clr_i,
    output logic                    check_done_o,
    output logic                    crc_error_o,
    output logic [NUM_CH-1:0]       ch_error_o,
    output logic                    stale_o,
    output logic [CNT_W-1:0]        err_count_o,
    output logic [1:0]              link_state_o,
    output logic                    link_fail_o
);

    localparam int NCHUNK = CRC_W / CMP_W;
    localparam int FC_W   = $clog2(FAIL_THRESH + 1);
    localparam int PC_W   = $clog2(GOOD_THRESH + 1);

    typedef enum logic [1:0] {
        ST_HEALTHY  = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAILED   = 2'd2
    } state_e;

    logic [NUM_CH*CRC_W-1:0]         exp_q, exp_d;
    logic                            pending_q, pending_d;
    logic                            s1_valid_q, s1_valid_d;
    logic                            s1_stale_q, s1_stale_d;
    logic [NUM_CH-1:0][NCHUNK-1:0]   s1_match_q, s1_match_d;
    logic                            done_q, done_d;
    logic                            crc_err_q, crc_err_d;
    logic [NUM_CH-1:0]               ch_err_q, ch_err_d;
    logic [NUM_CH-1:0]               ch_mis_s;
    logic                            stale_q, stale_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    state_e                          state_q, state_d;
    logic [FC_W-1:0]                 fail_cnt_q, fail_cnt_d, fail_inc_s;
    logic [PC_W-1:0]                 pass_cnt_q, pass_cnt_d, pass_inc_s;
    logic                            link_fail_q, link_fail_d;

    // Capture and stage-1 chunk compares; compare always sees the pre-edge expected word
    always_comb begin
        exp_d      = exp_q;
        pending_d  = pending_q;
        s1_valid_d = crc_valid_i;
        s1_stale_d = s1_stale_q;
        s1_match_d = s1_match_q;
        if (crc_valid_i) begin
            s1_stale_d = ~pending_q;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < NCHUNK; k++) begin
                    s1_match_d[c][k] = (exp_q[c*CRC_W + k*CMP_W +: CMP_W] ==
                                        crc_i[c*CRC_W + k*CMP_W +: CMP_W]) | ch_mask_i[c];
                end
            end
        end else begin
            s1_stale_d = s1_stale_q;
        end
        if (crc_boundary_i) begin
            exp_d     = expected_i;
            pending_d = 1'b1;
        end else if (crc_valid_i) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Stage-2 reduction; a stale check reports no per-channel errors
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_mis_s[c] = ~(&s1_match_q[c]) & ~s1_stale_q;
        end
        done_d    = s1_valid_q;
        ch_err_d  = ch_err_q;
        crc_err_d = crc_err_q;
        stale_d   = stale_q;
        if (s1_valid_q) begin
            ch_err_d  = ch_mis_s;
            crc_err_d = (|ch_mis_s) | s1_stale_q;
            stale_d   = s1_stale_q;
        end else begin
            stale_d   = stale_q;
        end
        if (clr_i) begin
            stale_d = 1'b0;
        end else begin
            stale_d = stale_d;
        end
    end

    // Health FSM and saturating error counter, driven by the registered check result
    always_comb begin
        state_d     = state_q;
        fail_cnt_d  = fail_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        cnt_d       = cnt_q;
        fail_inc_s  = fail_cnt_q + FC_W'(1);
        pass_inc_s  = pass_cnt_q + PC_W'(1);
        if (clr_i) begin
            state_d    = ST_HEALTHY;
            fail_cnt_d = '0;
            pass_cnt_d = '0;
            cnt_d      = '0;
        end else if (done_q) begin
            if (crc_err_q && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                ST_HEALTHY: begin
                    if (crc_err_q) begin
                        fail_cnt_d = FC_W'(1);
                        pass_cnt_d = '0;
                        state_d    = (FAIL_THRESH == 1) ? ST_FAILED : ST_DEGRADED;
                    end else begin
                        state_d = ST_HEALTHY;
                    end
                end
                ST_DEGRADED: begin
                    if (crc_err_q) begin
                        fail_cnt_d = fail_inc_s;
                        pass_cnt_d = '0;
                        state_d    = (fail_inc_s >= FC_W'(FAIL_THRESH)) ? ST_FAILED : ST_DEGRADED;
                    end else if (pass_inc_s >= PC_W'(GOOD_THRESH)) begin
                        fail_cnt_d = '0;
                        pass_cnt_d = '0;
                        state_d    = ST_HEALTHY;
                    end else begin
                        fail_cnt_d = '0;
                        pass_cnt_d = pass_inc_s;
                    end
                end
                ST_FAILED: state_d = ST_FAILED;
                default:   state_d = ST_HEALTHY;
            endcase
        end else begin
            state_d = state_q;
        end
        link_fail_d = (state_d == ST_FAILED);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            exp_q       <= '0;
            pending_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_stale_q  <= 1'b0;
            s1_match_q  <= '0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            ch_err_q    <= '0;
            stale_q     <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_HEALTHY;
            fail_cnt_q  <= '0;
            pass_cnt_q  <= '0;
            link_fail_q <= 1'b0;
        end else begin
            exp_q       <= exp_d;
            pending_q   <= pending_d;
            s1_valid_q  <= s1_valid_d;
            s1_stale_q  <= s1_stale_d;
            s1_match_q  <= s1_match_d;
            done_q      <= done_d;
            crc_err_q   <= crc_err_d;
            ch_err_q    <= ch_err_d;
            stale_q     <= stale_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            fail_cnt_q  <= fail_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            link_fail_q <= link_fail_d;
        end
    end

    assign check_done_o = done_q;
    assign crc_error_o  = crc_err_q;
    assign ch_error_o   = ch_err_q;
    assign stale_o      = stale_q;
    assign err_count_o  = cnt_q;
    assign link_state_o = state_q;
    assign link_fail_o  = link_fail_q;

endmodule

// File: tb/tb_qeciphy_crc_check_mc.sv
// Directed bench for qeciphy_crc_check_mc built with a 4-bit error counter so saturation is reachable.
module tb_qeciphy_crc_check_mc;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        crc_boundary_i;
    logic [63:0] expected_i;
    logic [63:0] crc_i;
    logic        crc_valid_i;
    logic [3:0]  ch_mask_i;
    logic        clr_i;
    logic        check_done_o;
    logic        crc_error_o;
    logic [3:0]  ch_error_o;
    logic        stale_o;
    logic [3:0]  err_count_o;
    logic [1:0]  link_state_o;
    logic        link_fail_o;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [63:0] GOOD = 64'h00FF_BEEF_1234_A5A5;
    localparam logic [63:0] BAD2 = 64'h00FF_BEEE_1234_A5A5;
    localparam logic [63:0] ALT  = 64'h1111_2222_3333_4444;

    qeciphy_crc_check_mc #(.CNT_W(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .crc_boundary_i(crc_boundary_i),
        .expected_i(expected_i), .crc_i(crc_i), .crc_valid_i(crc_valid_i),
        .ch_mask_i(ch_mask_i), .clr_i(clr_i), .check_done_o(check_done_o),
        .crc_error_o(crc_error_o), .ch_error_o(ch_error_o), .stale_o(stale_o),
        .err_count_o(err_count_o), .link_state_o(link_state_o), .link_fail_o(link_fail_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        crc_boundary_i = 1'b0;
        crc_valid_i    = 1'b0;
        clr_i          = 1'b0;
    endtask

    // boundary, valid one cycle later, result visible two edges after valid
    task automatic run(input string tag, input logic [63:0] e, input logic [63:0] c,
                       input logic [3:0] m, input logic xerr, input logic [3:0] xch);
        crc_boundary_i = 1'b1; expected_i = e; tick();
        crc_valid_i = 1'b1; crc_i = c; ch_mask_i = m; tick();
        chk({tag, "_nodone_early"}, check_done_o, 1'b0);
        tick();
        chk({tag, "_done"}, check_done_o, 1'b1);
        chk({tag, "_err"}, crc_error_o, xerr);
        chk({tag, "_ch"}, ch_error_o, xch);
        chk({tag, "_stale"}, stale_o, 1'b0);
        tick();
        chk({tag, "_pulse"}, check_done_o, 1'b0);
    endtask

    initial begin
        rst_n_i = 1'b0; crc_boundary_i = 1'b0; crc_valid_i = 1'b0; clr_i = 1'b0;
        expected_i = '0; crc_i = '0; ch_mask_i = '0;
        tick(); tick();
        chk("rst_done", check_done_o, 1'b0);
        chk("rst_err", crc_error_o, 1'b0);
        chk("rst_ch", ch_error_o, 4'h0);
        chk("rst_stale", stale_o, 1'b0);
        chk("rst_cnt", err_count_o, 4'h0);
        chk("rst_state", link_state_o, 2'd0);
        chk("rst_fail", link_fail_o, 1'b0);
        rst_n_i = 1'b1; tick();

        run("pass", GOOD, GOOD, 4'h0, 1'b0, 4'h0);
        chk("pass_cnt", err_count_o, 4'd0);
        chk("pass_state", link_state_o, 2'd0);
        run("ch2bad", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
        chk("ch2bad_cnt", err_count_o, 4'd1);
        chk("ch2bad_state", link_state_o, 2'd1);
        run("ch2mask", GOOD, BAD2, 4'b0100, 1'b0, 4'h0);
        chk("ch2mask_cnt", err_count_o, 4'd1);
        chk("ch2mask_state", link_state_o, 2'd1);
        clr_i = 1'b1; tick();
        chk("clr1_state", link_state_o, 2'd0);
        chk("clr1_cnt", err_count_o, 4'd0);

        // three consecutive fails reach FAILED, which then ignores passes
        run("f1", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
        chk("f1_state", link_state_o, 2'd1);
        run("f2", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
        chk("f2_state", link_state_o, 2'd1);
        chk("f2_lf", link_fail_o, 1'b0);
        run("f3", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
        chk("f3_state", link_state_o, 2'd2);
        chk("f3_lf", link_fail_o, 1'b1);
        chk("f3_cnt", err_count_o, 4'd3);
        for (int i = 0; i < 10; i++) run("sticky", GOOD, GOOD, 4'h0, 1'b0, 4'h0);
        chk("sticky_state", link_state_o, 2'd2);
        chk("sticky_lf", link_fail_o, 1'b1);
        clr_i = 1'b1; tick();
        chk("clr2_state", link_state_o, 2'd0);
        chk("clr2_lf", link_fail_o, 1'b0);
        chk("clr2_cnt", err_count_o, 4'd0);

        // recovery after GOOD_THRESH passes; alternating fail/pass stays DEGRADED
        run("d1", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) run("rec", GOOD, GOOD, 4'h0, 1'b0, 4'h0);
        chk("rec3_state", link_state_o, 2'd1);
        run("rec4", GOOD, GOOD, 4'h0, 1'b0, 4'h0);
        chk("rec4_state", link_state_o, 2'd0);
        for (int i = 0; i < 2; i++) begin
            run("alt_f", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
            chk("alt_f_state", link_state_o, 2'd1);
            run("alt_p", GOOD, GOOD, 4'h0, 1'b0, 4'h0);
            chk("alt_p_state", link_state_o, 2'd1);
        end
        for (int i = 0; i < 3; i++) run("alt_rec", GOOD, GOOD, 4'h0, 1'b0, 4'h0);
        chk("alt_rec_state", link_state_o, 2'd0);
        chk("alt_cnt", err_count_o, 4'd3);

        // one boundary, two back-to-back valids: second check is stale
        crc_boundary_i = 1'b1; expected_i = GOOD; tick();
        crc_valid_i = 1'b1; crc_i = GOOD; ch_mask_i = 4'h0; tick();
        crc_valid_i = 1'b1; tick();
        chk("b2b1_done", check_done_o, 1'b1);
        chk("b2b1_err", crc_error_o, 1'b0);
        chk("b2b1_stale", stale_o, 1'b0);
        tick();
        chk("stale_done", check_done_o, 1'b1);
        chk("stale_err", crc_error_o, 1'b1);
        chk("stale_ch", ch_error_o, 4'h0);
        chk("stale_flag", stale_o, 1'b1);
        tick();
        chk("stale_cnt", err_count_o, 4'd4);
        chk("stale_state", link_state_o, 2'd1);

        // boundary coincident with valid compares against the previous expected word
        crc_boundary_i = 1'b1; expected_i = GOOD; tick();
        crc_boundary_i = 1'b1; expected_i = ALT; crc_valid_i = 1'b1; crc_i = GOOD; tick();
        crc_valid_i = 1'b1; crc_i = ALT; tick();
        chk("coin_done", check_done_o, 1'b1);
        chk("coin_err", crc_error_o, 1'b0);
        chk("coin_stale", stale_o, 1'b0);
        tick();
        chk("coin2_done", check_done_o, 1'b1);
        chk("coin2_err", crc_error_o, 1'b0);
        chk("coin2_stale", stale_o, 1'b0);
        tick();

        run("allmask", GOOD, ~GOOD, 4'hF, 1'b0, 4'h0);

        // saturation of the 4-bit error counter
        clr_i = 1'b1; tick();
        for (int i = 0; i < 15; i++) run("sat", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
        chk("sat15_cnt", err_count_o, 4'hF);
        run("sat16", GOOD, BAD2, 4'h0, 1'b1, 4'b0100);
        chk("sat16_cnt", err_count_o, 4'hF);
        chk("sat16_state", link_state_o, 2'd2);

        // clear coincident with a failing check_done_o
        crc_boundary_i = 1'b1; expected_i = GOOD; tick();
        crc_valid_i = 1'b1; crc_i = BAD2; tick();
        tick();
        chk("clrc_done", check_done_o, 1'b1);
        clr_i = 1'b1; tick();
        chk("clrc_cnt", err_count_o, 4'd0);
        chk("clrc_state", link_state_o, 2'd0);
        chk("clrc_lf", link_fail_o, 1'b0);
        chk("clrc_err_held", crc_error_o, 1'b1);
        tick();
        chk("clrc_cnt2", err_count_o, 4'd0);

        // reset while a check is in flight drops it
        crc_boundary_i = 1'b1; expected_i = GOOD; tick();
        crc_valid_i = 1'b1; crc_i = BAD2; tick();
        rst_n_i = 1'b0; tick();
        chk("rstmid_done", check_done_o, 1'b0);
        rst_n_i = 1'b1; tick();
        chk("rstmid_done2", check_done_o, 1'b0);
        chk("rstmid_err", crc_error_o, 1'b0);
        crc_valid_i = 1'b1; crc_i = '0; tick();
        tick();
        chk("post_rst_done", check_done_o, 1'b1);
        chk("post_rst_stale", stale_o, 1'b1);
        chk("post_rst_err", crc_error_o, 1'b1);
        tick();
        chk("post_rst_cnt", err_count_o, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
